// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared state encoding and byte-lane constants for the boot loader
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN0,
    LEN1,
    DATA,
    CSUM,
    DONE,
    ERR
  } loader_state_e;

  localparam int LEN_W  = 16;
  localparam int BYTE_W = 8;
  localparam int LANES  = 4;
  localparam int LANE_W = 2;
  localparam logic [LANE_W-1:0] LAST_LANE = 2'd3;

endpackage

// File: rtl/imem_word_packer.sv
// rtl/imem_word_packer.sv - packs bytes LSB-first into 32-bit words, one-cycle word_valid pulse
module imem_word_packer
  import imem_loader_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_clear,
  input  logic                i_byte_valid,
  input  logic [BYTE_W-1:0]   i_byte,
  output logic                o_word_valid,
  output logic [31:0]         o_word
);

  logic [23:0]       shift_q, shift_d;
  logic [LANE_W-1:0] lane_q, lane_d;
  logic              word_valid_q, word_valid_d;
  logic [31:0]       word_q, word_d;

  // Each new byte enters at the top so that byte0 ends up in bits [7:0].
  always_comb begin
    shift_d      = shift_q;
    lane_d       = lane_q;
    word_d       = word_q;
    word_valid_d = 1'b0;
    if (i_clear) begin
      shift_d = '0;
      lane_d  = '0;
    end else if (i_byte_valid) begin
      if (lane_q == LAST_LANE) begin
        word_d       = {i_byte, shift_q};
        word_valid_d = 1'b1;
        lane_d       = '0;
      end else begin
        shift_d = {i_byte, shift_q[23:8]};
        lane_d  = lane_q + LANE_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      shift_q      <= '0;
      lane_q       <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
    end else begin
      shift_q      <= shift_d;
      lane_q       <= lane_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
    end
  end

  assign o_word_valid = word_valid_q;
  assign o_word       = word_q;

endmodule

// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - streams a length-prefixed image into IMEM, then releases the core
// Optional trailing checksum byte enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_boot_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_valid,
  output logic              o_rx_ready,
  input  logic [ADDR_W-1:0] i_fetch_addr,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  output logic              o_mem_wren,
  output logic              o_cpu_rst,
  output logic              o_done,
  output logic              o_err
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int TO_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYC);
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam loader_state_e AFTER_DATA = CSUM;
`else
  localparam loader_state_e AFTER_DATA = DONE;
`endif

  loader_state_e     state_q, state_d;
  logic [7:0]        len_lo_q, len_lo_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [ADDR_W-1:0] wcnt_q, wcnt_d;
  logic [TO_W-1:0]   tcnt_q, tcnt_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        sum_q, sum_d;
`endif

  logic              rx_ready, accept, last_word, word_done_last;
  logic              pk_clear, pk_valid, word_valid;
  logic [31:0]       word;
  logic [LEN_W-1:0]  len_n;

  imem_word_packer u_packer (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_clear     (pk_clear),
    .i_byte_valid(pk_valid),
    .i_byte      (i_rx_data),
    .o_word_valid(word_valid),
    .o_word      (word)
  );

  assign len_n          = {i_rx_data, len_lo_q};
  assign last_word      = (LEN_W'(wcnt_q) == len_q - LEN_W'(1));
  assign word_done_last = word_valid && last_word;
  // Stop taking bytes while the final word is being written so nothing leaks into the packer.
  assign rx_ready = (state_q inside {LEN0, LEN1, CSUM}) || (state_q == DATA && !word_done_last);
  assign accept   = i_rx_valid && rx_ready;
  assign pk_valid = accept && (state_q == DATA);

  always_comb begin
    state_d  = state_q;
    len_lo_d = len_lo_q;
    len_d    = len_q;
    wcnt_d   = wcnt_q;
    tcnt_d   = '0;
    pk_clear = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    sum_d    = sum_q;
    if (accept && (state_q inside {LEN0, LEN1, DATA})) sum_d = sum_q + i_rx_data;
`endif
    case (state_q)
      IDLE, DONE, ERR: begin
        if (i_start) begin
          state_d  = LEN0;
          wcnt_d   = '0;
          pk_clear = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum_d    = '0;
`endif
        end
      end
      LEN0: begin
        if (accept) begin
          len_lo_d = i_rx_data;
          state_d  = LEN1;
        end
      end
      LEN1: begin
        if (accept) begin
          len_d = len_n;
          if (32'(len_n) > DEPTH) state_d = ERR;
          else if (len_n == '0)   state_d = AFTER_DATA;
          else                    state_d = DATA;
        end
      end
      DATA: begin
        if (word_valid) begin
          if (last_word) state_d = AFTER_DATA;
          else           wcnt_d  = wcnt_q + ADDR_W'(1);
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CSUM: begin
        if (accept) state_d = (sum_q + i_rx_data == 8'h00) ? DONE : ERR;
      end
`endif
      default: state_d = IDLE;
    endcase

    // Idle-gap watchdog; a completed image in the same cycle takes priority.
    if (state_q inside {LEN0, LEN1, DATA, CSUM}) begin
      if (accept)                   tcnt_d = '0;
      else if (tcnt_q != TO_LIMIT)  tcnt_d = tcnt_q + TO_W'(1);
      else                          tcnt_d = tcnt_q;
      if (TIMEOUT_CYC != 0 && !accept && tcnt_d == TO_LIMIT && state_d == state_q)
        state_d = ERR;
    end

    cpu_rst_d = (state_d != DONE);
    done_d    = (state_d == DONE);
    err_d     = (state_d == ERR);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      len_lo_q  <= '0;
      len_q     <= '0;
      wcnt_q    <= '0;
      tcnt_q    <= '0;
      cpu_rst_q <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      len_lo_q  <= len_lo_d;
      len_q     <= len_d;
      wcnt_q    <= wcnt_d;
      tcnt_q    <= tcnt_d;
      cpu_rst_q <= cpu_rst_d;
      done_q    <= done_d;
      err_q     <= err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q     <= sum_d;
`endif
    end
  end

  assign o_rx_ready  = rx_ready;
  assign o_mem_addr  = (state_q == DONE) ? i_fetch_addr : wcnt_q;
  assign o_mem_wdata = word;
  assign o_mem_wren  = word_valid;
  assign o_cpu_rst   = cpu_rst_q;
  assign o_done      = done_q;
  assign o_err       = err_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb/tb_imem_boot_loader.sv - directed self-checking bench for imem_boot_loader
module tb_imem_boot_loader;

  logic        clk = 1'b0;
  logic        rst, start, rx_valid, rx_ready, wren, cpu_rst, done, err;
  logic [7:0]  rx_data, fetch_addr, mem_addr;
  logic [31:0] wdata;

  int errors = 0;
  int checks = 0;
  int gap_max = 0;
  logic [7:0]  img[$];
  logic [7:0]  wa_q[$];
  logic [31:0] wd_q[$];

  always #5 clk = ~clk;

  imem_boot_loader #(.ADDR_W(8), .TIMEOUT_CYC(16)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (start),
    .i_rx_data   (rx_data),
    .i_rx_valid  (rx_valid),
    .o_rx_ready  (rx_ready),
    .i_fetch_addr(fetch_addr),
    .o_mem_addr  (mem_addr),
    .o_mem_wdata (wdata),
    .o_mem_wren  (wren),
    .o_cpu_rst   (cpu_rst),
    .o_done      (done),
    .o_err       (err)
  );

  always @(negedge clk) begin
    if (wren === 1'b1) begin
      wa_q.push_back(mem_addr);
      wd_q.push_back(wdata);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Called at a negedge; returns at the negedge after the byte is accepted with valid still high.
  task automatic send_byte(input logic [7:0] b);
    int  n;
    logic r;
    n = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    checks++;
    forever begin
      r = rx_ready;
      @(posedge clk);
      if (r) break;
      n++;
      if (n > 64) begin
        errors++;
        $display("FAIL accept: byte %h not accepted, got ready=%b want 1", b, r);
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic send_img();
    logic [7:0] s;
    s = 8'h00;
    foreach (img[i]) begin
      if (gap_max > 0) begin
        rx_valid = 1'b0;
        repeat ($urandom_range(0, gap_max)) @(negedge clk);
      end
      send_byte(img[i]);
      s = s + img[i];
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h00 - s);
`endif
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wa_q.delete();
    wd_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; fetch_addr = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++; if (cpu_rst !== 1'b1) begin errors++; $display("FAIL rst_cpu_rst: got %b want 1", cpu_rst); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", done); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", err); end
    checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL rst_rx_ready: got %b want 0", rx_ready); end
    checks++; if (wren !== 1'b0) begin errors++; $display("FAIL rst_wren: got %b want 0", wren); end
    checks++; if (wdata !== 32'h0) begin errors++; $display("FAIL rst_wdata: got %h want 00000000", wdata); end
  endtask

  task automatic test_load_two();
    pulse_start();
    img = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    send_img();
    checks++; if (wa_q.size() !== 2) begin errors++; $display("FAIL load2_count: got %0d want 2", wa_q.size()); end
    if (wa_q.size() == 2) begin
      checks++; if (wa_q[0] !== 8'h00 || wd_q[0] !== 32'h00000013) begin errors++; $display("FAIL load2_w0: got %h@%h want 00000013@00", wd_q[0], wa_q[0]); end
      checks++; if (wa_q[1] !== 8'h01 || wd_q[1] !== 32'h00100093) begin errors++; $display("FAIL load2_w1: got %h@%h want 00100093@01", wd_q[1], wa_q[1]); end
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL load2_done: got %b want 1", done); end
    checks++; if (cpu_rst !== 1'b0) begin errors++; $display("FAIL load2_cpu_rst: got %b want 0", cpu_rst); end
    checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL load2_rx_ready: got %b want 0", rx_ready); end
    fetch_addr = 8'h05;
    #1;
    checks++; if (mem_addr !== 8'h05) begin errors++; $display("FAIL load2_fetch_mux: got %h want 05", mem_addr); end
    fetch_addr = 8'h00;
  endtask

  task automatic test_len_zero();
    pulse_start();
    img = '{8'h00, 8'h00};
    send_img();
    checks++; if (done !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL len0_done: got done=%b err=%b want 1 0", done, err); end
    checks++; if (wa_q.size() !== 0) begin errors++; $display("FAIL len0_writes: got %0d want 0", wa_q.size()); end
  endtask

  task automatic test_len_error();
    pulse_start();
    send_byte(8'h01);
    send_byte(8'h01);
    rx_valid = 1'b0;
    #1;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL lenerr_err: got %b want 1", err); end
    checks++; if (cpu_rst !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL lenerr_hold: got cpu_rst=%b done=%b want 1 0", cpu_rst, done); end
    repeat (4) @(negedge clk);
    checks++; if (wa_q.size() !== 0) begin errors++; $display("FAIL lenerr_writes: got %0d want 0", wa_q.size()); end
    checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL lenerr_rx_ready: got %b want 0", rx_ready); end
  endtask

  task automatic test_timeout();
    pulse_start();
    checks++; if (err !== 1'b0 || cpu_rst !== 1'b1) begin errors++; $display("FAIL tmo_restart: got err=%b cpu_rst=%b want 0 1", err, cpu_rst); end
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h13);
    rx_valid = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL tmo_early: got err=%b want 0 at 15 cycles", err); end
    @(posedge clk);
    #1;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL tmo_fire: got err=%b want 1 at 16 cycles", err); end
    checks++; if (wa_q.size() !== 0) begin errors++; $display("FAIL tmo_writes: got %0d want 0", wa_q.size()); end
  endtask

  task automatic test_reset_mid_load();
    pulse_start();
    img = '{8'h03, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    foreach (img[i]) send_byte(img[i]);
    rx_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (wa_q.size() !== 1 || wd_q[0] !== 32'h44332211) begin errors++; $display("FAIL midrst_partial: got %0d writes want 1 of 44332211", wa_q.size()); end
    checks++; if (rx_ready !== 1'b0 || cpu_rst !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL midrst_idle: got ready=%b cpu_rst=%b done=%b err=%b want 0 1 0 0", rx_ready, cpu_rst, done, err);
    end
    pulse_start();
    img = '{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    send_img();
    checks++; if (wa_q.size() !== 1 || wa_q[0] !== 8'h00 || wd_q[0] !== 32'hDDCCBBAA) begin
      errors++; $display("FAIL midrst_reload: got %0d writes want 1 of DDCCBBAA@00", wa_q.size());
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL midrst_done: got %b want 1", done); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_w[3];
    exp_w = '{32'hDEADBEEF, 32'h01234567, 32'h80000001};
    gap_max = 3;
    pulse_start();
    img = '{8'h03, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h67, 8'h45, 8'h23, 8'h01, 8'h01, 8'h00, 8'h00, 8'h80};
    send_img();
    gap_max = 0;
    checks++; if (wa_q.size() !== 3) begin errors++; $display("FAIL bp_count: got %0d want 3", wa_q.size()); end
    for (int k = 0; k < 3; k++) begin
      if (k < wa_q.size()) begin
        checks++;
        if (wa_q[k] !== 8'(k) || wd_q[k] !== exp_w[k]) begin
          errors++; $display("FAIL bp_word%0d: got %h@%h want %h@%h", k, wd_q[k], wa_q[k], exp_w[k], 8'(k));
        end
      end
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL bp_done: got %b want 1", done); end
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    pulse_start();
    img = '{8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'hFE};
    foreach (img[i]) send_byte(img[i]);
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (done !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL csum_good: got done=%b err=%b want 1 0", done, err); end
    checks++; if (wa_q.size() !== 1 || wd_q[0] !== 32'h00000001) begin errors++; $display("FAIL csum_word: got %0d writes want 1 of 00000001", wa_q.size()); end
    pulse_start();
    img = '{8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'hFF};
    foreach (img[i]) send_byte(img[i]);
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (err !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL csum_bad: got done=%b err=%b want 0 1", done, err); end
  endtask
`endif

  initial begin
    test_reset();
    test_load_two();
    test_len_zero();
    test_len_error();
    test_timeout();
    test_reset_mid_load();
    test_back_to_back();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
